// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU arbiter slice: data width, opcodes, FSM states.
package alu_pkg;

    localparam int DATA_W = 6;

    localparam logic [1:0] OP_INC_ADD = 2'b00;
    localparam logic [1:0] OP_PASS_A  = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_SUB     = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 6-bit ALU: a+b+1, pass a, a&b, a-b (all modulo 2^DATA_W).
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] f
);

    always_comb begin
        // NOTE: default assignment first so no path leaves f unassigned (no latch).
        f = '0;
        case (op)
            OP_INC_ADD: f = a + b + DATA_W'(1);
            OP_PASS_A:  f = a;
            OP_AND:     f = a & b;
            OP_SUB:     f = a - b;
            default:    f = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU; IDLE/EXEC/DONE handshake FSM.
// Optional per-requester saturating grant counters under `ALU_ARB_GRANT_CNT_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [1:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [1:0]        req1_op,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_id
`ifdef ALU_ARB_GRANT_CNT_EN
    ,
    output logic [7:0]        grant0_cnt,
    output logic [7:0]        grant1_cnt
`endif
);

    state_t            state;
    logic              last_served;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        op_q;
    logic              id_q;
    logic              grant_id;
    logic              accept_ok;
    logic              hs0;
    logic              hs1;
    logic [DATA_W-1:0] alu_f;

    // On a tie, round-robin picks whoever was not served last; fixed mode always picks 0.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid)
            grant_id = (PRIO_MODE == 1) ? 1'b0 : ~last_served;
        else if (req1_valid)
            grant_id = 1'b1;
    end

    // rst_n gates ready so nothing is offered while the block is held in reset.
    assign accept_ok  = (state == IDLE) && rst_n;
    assign req0_ready = accept_ok && req0_valid && !grant_id;
    assign req1_ready = accept_ok && req1_valid &&  grant_id;
    assign hs0        = req0_valid && req0_ready;
    assign hs1        = req1_valid && req1_ready;

    alu u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .f  (alu_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand registers are reset too, so the ALU never sees X after reset.
            state       <= IDLE;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_id      <= 1'b0;
            last_served <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here; every flop samples pre-edge values.
            case (state)
                IDLE: begin
                    if (hs0 || hs1) begin
                        a_q         <= hs1 ? req1_a  : req0_a;
                        b_q         <= hs1 ? req1_b  : req0_b;
                        op_q        <= hs1 ? req1_op : req0_op;
                        id_q        <= hs1;
                        last_served <= hs1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= alu_f;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_GRANT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant0_cnt <= 8'd0;
            grant1_cnt <= 8'd0;
        end else begin
            if (hs0) grant0_cnt <= sat_inc8(grant0_cnt);
            if (hs1) grant1_cnt <= sat_inc8(grant1_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table + scoreboard, plus stall, reset and arbitration sequences.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, res_ready;
    logic [5:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;

    logic       req0_ready, req1_ready, res_valid, res_id;
    logic [5:0] res_data;
    logic       fp_req0_ready, fp_req1_ready, fp_res_valid, fp_res_id;
    logic [5:0] fp_res_data;
`ifdef ALU_ARB_GRANT_CNT_EN
    logic [7:0] grant0_cnt, grant1_cnt, fp_grant0_cnt, fp_grant1_cnt;
`endif

    alu_arbiter #(.PRIO_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id)
`ifdef ALU_ARB_GRANT_CNT_EN
        , .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt)
`endif
    );

    alu_arbiter #(.PRIO_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .res_valid(fp_res_valid), .res_ready(res_ready),
        .res_data(fp_res_data), .res_id(fp_res_id)
`ifdef ALU_ARB_GRANT_CNT_EN
        , .grant0_cnt(fp_grant0_cnt), .grant1_cnt(fp_grant1_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int hs0_total = 0;

    typedef struct {
        logic [5:0] data;
        logic       id;
        int         hs_cyc;
    } exp_t;

    typedef struct {
        logic       req;
        logic [5:0] a;
        logic [5:0] b;
        logic [1:0] op;
        logic [5:0] exp;
    } vec_t;

    exp_t       sb[$];
    int         served[$];
    int         fp_served[$];
    logic [5:0] pend_exp0 = '0;
    logic [5:0] pend_exp1 = '0;
    logic       prev_valid = 1'b0;
    vec_t       vec[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on request handshake, pop and compare on result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (req0_valid && req0_ready) begin
            sb.push_back('{pend_exp0, 1'b0, cyc});
            served.push_back(0);
            hs0_total++;
        end
        if (req1_valid && req1_ready) begin
            sb.push_back('{pend_exp1, 1'b1, cyc});
            served.push_back(1);
        end
        if (req0_valid && fp_req0_ready) fp_served.push_back(0);
        if (req1_valid && fp_req1_ready) fp_served.push_back(1);
        if (res_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got data 0x%0h id %0d, expected no result", res_data, res_id);
            end else begin
                check("latency", cyc, sb[0].hs_cyc + 2);
            end
        end
        if (res_valid && res_ready && sb.size() != 0) begin
            e = sb.pop_front();
            check("res_data", res_data, e.data);
            check("res_id", res_id, e.id);
        end
        if (res_valid) check("ready_low_in_done", {req0_ready, req1_ready}, 0);
        check("ready_onehot", req0_ready && req1_ready, 0);
        prev_valid <= res_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic r, input logic [5:0] a, input logic [5:0] b,
                         input logic [1:0] op, input logic [5:0] exp);
        bit done = 0;
        if (r) begin
            req1_a = a; req1_b = b; req1_op = op; pend_exp1 = exp; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; pend_exp0 = exp; req0_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (r ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) done = 1;
        end
        if (!done) fail("issue_handshake");
        tick();
        if (r) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            if (sb.size() == 0 && !res_valid) done = 1;
        end
        if (!done) fail("drain");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        int start;

        vec[0] = '{1'b0, 6'h05, 6'h03, 2'b00, 6'h09};
        vec[1] = '{1'b1, 6'h05, 6'h07, 2'b11, 6'h3E};
        vec[2] = '{1'b1, 6'h15, 6'h2A, 2'b01, 6'h15};
        vec[3] = '{1'b0, 6'h3F, 6'h3F, 2'b00, 6'h3F};
        vec[4] = '{1'b0, 6'h00, 6'h3F, 2'b01, 6'h00};
        vec[5] = '{1'b1, 6'h00, 6'h01, 2'b11, 6'h3F};
        vec[6] = '{1'b0, 6'h3F, 6'h2A, 2'b10, 6'h2A};
        vec[7] = '{1'b1, 6'h3F, 6'h3F, 2'b11, 6'h00};
        vec[8] = '{1'b0, 6'h20, 6'h1F, 2'b00, 6'h00};
        vec[9] = '{1'b1, 6'h2C, 6'h1E, 2'b10, 6'h0C};

        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        #12;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_id", res_id, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        tick();

        foreach (vec[i]) begin
            issue(vec[i].req, vec[i].a, vec[i].b, vec[i].op, vec[i].exp);
            drain();
        end

        // Result registers keep the last value once back in IDLE.
        tick(); tick(); tick();
        check("retain_data", res_data, 6'h0C);
        check("retain_id", res_id, 1);

        // Consumer stall in DONE with another request waiting.
        res_ready = 1'b0;
        issue(1'b0, 6'h10, 6'h03, 2'b11, 6'h0D);
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (res_valid) done = 1;
        end
        if (!done) fail("stall_wait_valid");
        req1_a = 6'h02; req1_b = 6'h02; req1_op = 2'b00; pend_exp1 = 6'h05; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", res_valid, 1);
            check("stall_data", res_data, 6'h0D);
            check("stall_id", res_id, 0);
            check("stall_ready", {req0_ready, req1_ready}, 0);
        end
        res_ready = 1'b1;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (req1_valid && req1_ready) done = 1;
        end
        if (!done) fail("stall_req1_handshake");
        tick();
        req1_valid = 1'b0;
        drain();

        // Reset pulsed while an operation is in EXEC.
        issue(1'b1, 6'h3F, 6'h3F, 2'b10, 6'h3F);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("exec_rst_valid", res_valid, 0);
        check("exec_rst_data", res_data, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("exec_rst_no_result", res_valid, 0);
        end
        issue(1'b0, 6'h01, 6'h01, 2'b00, 6'h03);
        drain();

        // Both requesters valid from reset.
        do_reset();
        served.delete();
        fp_served.delete();
        req0_a = 6'h01; req0_b = 6'h02; req0_op = 2'b00; pend_exp0 = 6'h04;
        req1_a = 6'h09; req1_b = 6'h04; req1_op = 2'b11; pend_exp1 = 6'h05;
        req0_valid = 1'b1; req1_valid = 1'b1;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (served.size() >= 4 && fp_served.size() >= 4) done = 1;
        end
        if (!done) fail("tie_four_grants");
        tick();
        req0_valid = 1'b0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (fp_served.size() >= 5) done = 1;
        end
        if (!done) fail("tie_fp_req1_grant");
        tick();
        req1_valid = 1'b0;
        drain();
        if (served.size() >= 4 && fp_served.size() >= 5) begin
            check("rr_order0", served[0], 0);
            check("rr_order1", served[1], 1);
            check("rr_order2", served[2], 0);
            check("rr_order3", served[3], 1);
            check("fp_order0", fp_served[0], 0);
            check("fp_order1", fp_served[1], 0);
            check("fp_order2", fp_served[2], 0);
            check("fp_order3", fp_served[3], 0);
            check("fp_order4", fp_served[4], 1);
        end else begin
            fail("tie_order_length");
        end

`ifdef ALU_ARB_GRANT_CNT_EN
        do_reset();
        check("cnt_rst0", grant0_cnt, 0);
        check("cnt_rst1", grant1_cnt, 0);
        start = hs0_total;
        req0_a = 6'h07; req0_b = 6'h00; req0_op = 2'b01; pend_exp0 = 6'h07;
        req0_valid = 1'b1;
        done = 0;
        for (int i = 0; i < 1200 && !done; i++) begin
            @(negedge clk);
            if (hs0_total - start >= 300) done = 1;
        end
        if (!done) fail("cnt_300_handshakes");
        tick();
        req0_valid = 1'b0;
        drain();
        check("cnt_sat0", grant0_cnt, 8'd255);
        check("cnt_sat1", grant1_cnt, 8'd0);
`else
        start = hs0_total;
        check("hs0_counted", (hs0_total - start), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
